// File: rtl/verify_pkg.sv
// Shared constants and helpers for the verify platform reporter.
// Holds ASCII codes, the nibble-to-ASCII helper and the default baud divisor.
package verify_pkg;

    // 50 MHz / 115200 baud
    localparam int DEFAULT_CLKS_PER_BIT = 434;

    localparam logic [7:0] ASCII_T  = 8'h54;
    localparam logic [7:0] ASCII_C  = 8'h43;
    localparam logic [7:0] ASCII_EQ = 8'h3D;
    localparam logic [7:0] ASCII_SP = 8'h20;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    // 0-9 -> '0'-'9', A-F -> 'A'-'F' (uppercase)
    function automatic logic [7:0] nibble_to_ascii(input logic [3:0] n);
        logic [7:0] r;
        if (n < 4'd10) begin
            r = {4'h3, n};
        end else begin
            r = 8'h37 + {4'h0, n};
        end
        return r;
    endfunction

endpackage

// File: rtl/score_reporter_if.sv
// Bundle between the scoreboard/host side and the score reporter.
// Ports: total/correct/report toward the reporter; uart_tx/busy/done back.
interface score_reporter_if #(
    parameter int CNT_W = 32
);
    logic [CNT_W-1:0] total;
    logic [CNT_W-1:0] correct;
    logic             report;
    logic             uart_tx;
    logic             busy;
    logic             done;

    modport master (
        output total, correct, report,
        input  uart_tx, busy, done
    );

    modport slave (
        input  total, correct, report,
        output uart_tx, busy, done
    );
endinterface

// File: rtl/uart_byte_tx.sv
// 8N1 byte serializer: start bit, 8 data bits LSB first, stop bit.
// Ports: clk, rst_n, start (load data), data[7:0], tx (idle high), byte_done.
module uart_byte_tx
    import verify_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       byte_done
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);

    // Frame shifted out from bit 0; ones fill in behind so the
    // line returns high as soon as the stop bit is over.
    logic [9:0]    shreg;
    logic [CW-1:0] clk_cnt;
    logic [3:0]    bit_idx;
    logic          active;

    assign tx = shreg[0];

    // High during the last cycle of the stop bit, so a new start
    // issued on that edge follows with no idle gap.
    assign byte_done = active && (bit_idx == 4'd9) &&
                       (clk_cnt == CLK_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg   <= '1;
            clk_cnt <= '0;
            bit_idx <= '0;
            active  <= 1'b0;
        end else if (start) begin
            shreg   <= {1'b1, data, 1'b0};
            clk_cnt <= '0;
            bit_idx <= '0;
            active  <= 1'b1;
        end else if (active) begin
            if (clk_cnt == CLK_LAST) begin
                clk_cnt <= '0;
                shreg   <= {1'b1, shreg[9:1]};
                bit_idx <= bit_idx + 4'd1;
                if (bit_idx == 4'd9) begin
                    active <= 1'b0;
                end
            end else begin
                clk_cnt <= clk_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/score_reporter.sv
// Snapshots scoreboard counters and prints "T=<hex> C=<hex>\r\n" over UART.
// Ports: clk, rst_n, bus (slave: total, correct, report, uart_tx, busy, done).
module score_reporter
    import verify_pkg::*;
#(
    parameter int CNT_W        = 32,
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int PERIOD       = 50_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    score_reporter_if.slave  bus
);
    localparam int DIGITS = CNT_W / 4;
    localparam int NCHAR  = 2 * DIGITS + 7;
    localparam int IDX_W  = $clog2(NCHAR);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHAR - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_SEND = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]       state;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] snap_t;
    logic [CNT_W-1:0] snap_c;
    logic [7:0]       next_char;
    logic             pending;
    logic             per_fire;
    logic             trigger;
    logic             go;
    logic             start;
    logic [7:0]       tx_data;
    logic             byte_done;
    logic             tx;

    function automatic logic [7:0] char_at(
        input int               i,
        input logic [CNT_W-1:0] t,
        input logic [CNT_W-1:0] c
    );
        logic [CNT_W-1:0] sh;
        logic [7:0]       ch;
        sh = '0;
        ch = ASCII_LF;
        unique case (1'b1)
            (i == 0): ch = ASCII_T;
            (i == 1): ch = ASCII_EQ;
            (i >= 2 && i < 2 + DIGITS): begin
                sh = t >> (4 * (DIGITS + 1 - i));
                ch = nibble_to_ascii(sh[3:0]);
            end
            (i == 2 + DIGITS): ch = ASCII_SP;
            (i == 3 + DIGITS): ch = ASCII_C;
            (i == 4 + DIGITS): ch = ASCII_EQ;
            (i >= 5 + DIGITS && i < 5 + 2 * DIGITS): begin
                sh = c >> (4 * (2 * DIGITS + 4 - i));
                ch = nibble_to_ascii(sh[3:0]);
            end
            (i == 5 + 2 * DIGITS): ch = ASCII_CR;
            default: ch = ASCII_LF;
        endcase
        return ch;
    endfunction

    if (PERIOD > 0) begin : g_per
        localparam int PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
        logic [PW-1:0] per_cnt;

        assign per_fire = (per_cnt == PW'(PERIOD - 1));

        // Free-running; not gated by an active line.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                per_cnt <= '0;
            end else if (per_fire) begin
                per_cnt <= '0;
            end else begin
                per_cnt <= per_cnt + PW'(1);
            end
        end
    end else begin : g_noper
        assign per_fire = 1'b0;
    end

    assign trigger = bus.report | per_fire;
    assign go      = trigger | pending;

    // The first character is constant, so a line can start on the
    // same edge the trigger is seen. Later characters are prepared
    // in LOAD while the previous byte is still on the wire.
    always_comb begin
        start   = 1'b0;
        tx_data = next_char;
        unique case (state)
            S_IDLE, S_DONE: begin
                if (go) begin
                    start   = 1'b1;
                    tx_data = ASCII_T;
                end
            end
            S_SEND: begin
                if (byte_done && idx != LAST_IDX) begin
                    start = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            idx       <= '0;
            snap_t    <= '0;
            snap_c    <= '0;
            next_char <= '0;
            pending   <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (go) begin
                        snap_t  <= bus.total;
                        snap_c  <= bus.correct;
                        pending <= 1'b0;
                        idx     <= '0;
                        state   <= S_LOAD;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_LOAD: begin
                    if (trigger) pending <= 1'b1;
                    next_char <= char_at(int'(idx) + 1, snap_t, snap_c);
                    state     <= S_SEND;
                end
                S_SEND: begin
                    if (trigger) pending <= 1'b1;
                    if (byte_done) begin
                        if (idx == LAST_IDX) begin
                            state <= S_DONE;
                        end else begin
                            idx   <= idx + IDX_W'(1);
                            state <= S_LOAD;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    uart_byte_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .data     (tx_data),
        .tx       (tx),
        .byte_done(byte_done)
    );

    assign bus.uart_tx = tx;
    assign bus.busy    = (state == S_LOAD) || (state == S_SEND);
    assign bus.done    = (state == S_DONE);

endmodule
